// File: rtl/div_32bit_seq_pkg.sv
// Shared ALU definitions: divider FSM states, step count and two's-complement helper.
// Imported by the sequential divider and its datapath.
package div_32bit_seq_pkg;

   localparam int XLEN      = 32;
   localparam int DIV_STEPS = 32;
   localparam int CNT_W     = $clog2(DIV_STEPS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   // Inversion plus one; 0x80000000 maps onto itself, which is the correct magnitude.
   function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] x);
      return ~x + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/full_adder_32bit.sv
// 32-bit adder with carry-in and carry-out; combinational, no backpressure.
module full_adder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [32:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {32'd0, cin};
   assign sum   = total[31:0];
   assign cout  = total[32];

endmodule

// File: rtl/div_32bit_seq.sv
// Sequential restoring divider, signed/unsigned, RISC-V DIV/REM semantics.
// Fixed latency: o_done 34 cycles after the accepting cycle; i_start ignored while busy.
module div_32bit_seq
   import div_32bit_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   div_state_e       state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             neg_quo;
   logic             neg_rem;

   logic             dend_neg;
   logic             dvs_neg;
   logic [WIDTH-1:0] neg_a_in;
   logic [WIDTH-1:0] neg_b_in;
   logic [WIDTH-1:0] neg_a;
   logic [WIDTH-1:0] neg_b;
   logic [WIDTH-1:0] shift_rem;
   logic [WIDTH-1:0] dvs_inv;
   logic [WIDTH-1:0] diff;
   logic             carry;
   logic             no_borrow;

   assign dend_neg = i_signed & i_dividend[WIDTH-1];
   assign dvs_neg  = i_signed & i_divisor[WIDTH-1];

   // One pair of negators serves both operand capture (IDLE) and sign fix-up (FIX).
   assign neg_a_in = (state == IDLE) ? i_dividend : quo;
   assign neg_b_in = (state == IDLE) ? i_divisor  : rem;
   assign neg_a    = twos_neg(neg_a_in);
   assign neg_b    = twos_neg(neg_b_in);

   assign shift_rem = {rem[WIDTH-2:0], quo[WIDTH-1]};
   assign dvs_inv   = ~dvs;

   full_adder_32bit u_trial_sub (
      .a    (shift_rem),
      .b    (dvs_inv),
      .cin  (1'b1),
      .sum  (diff),
      .cout (carry)
   );

   // The bit shifted out of rem makes the partial remainder exceed any divisor.
   assign no_borrow = carry | rem[WIDTH-1];

   assign o_busy = (state != IDLE);
   assign o_done = (state == DONE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         count       <= '0;
         rem         <= '0;
         quo         <= '0;
         dvs         <= '0;
         neg_quo     <= 1'b0;
         neg_rem     <= 1'b0;
         o_quotient  <= '0;
         o_remainder <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  state   <= CALC;
                  count   <= CNT_W'(DIV_STEPS - 1);
                  rem     <= '0;
                  quo     <= dend_neg ? neg_a : i_dividend;
                  dvs     <= dvs_neg  ? neg_b : i_divisor;
                  // Divide-by-zero keeps the all-ones quotient regardless of sign.
                  neg_quo <= (dend_neg ^ dvs_neg) & (|i_divisor);
                  neg_rem <= dend_neg;
               end
            end
            CALC: begin
               rem   <= no_borrow ? diff : shift_rem;
               quo   <= {quo[WIDTH-2:0], no_borrow};
               count <= count - 1'b1;
               if (count == '0) begin
                  state <= FIX;
               end
            end
            FIX: begin
               o_quotient  <= neg_quo ? neg_a : quo;
               o_remainder <= neg_rem ? neg_b : rem;
               state       <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/div_32bit_seq.md
DIV_32BIT_SEQ -- requirements
Module: div_32bit_seq

Interface
REQ-001 The block SHALL have exactly one parameter: WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_start  input  1  request a division; sampled only in IDLE.
REQ-005 i_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-006 i_dividend  input  32  operand A, captured on the accepting edge.
REQ-007 i_divisor  input  32  operand B, captured on the accepting edge.
REQ-008 o_busy  output  1  high whenever the state is not IDLE.
REQ-009 o_done  output  1  one-cycle pulse; results are valid in that cycle.
REQ-010 o_quotient  output  32  registered quotient.
REQ-011 o_remainder  output  32  registered remainder.

Function
REQ-012 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-013 In IDLE with i_start=1, the next edge SHALL latch the operands and go to CALC with the bit counter at 31.
REQ-014 When i_signed=1, the captured operands SHALL be converted to magnitudes and their signs stored; when i_signed=0 they SHALL be used as-is.
REQ-015 Each CALC edge SHALL run one restoring step: shift {rem,quo} left by 1, trial-subtract the divisor magnitude from rem, keep the difference and set quo[0]=1 if no borrow, else set quo[0]=0.
REQ-016 After 32 CALC edges the FSM SHALL enter FIX.
REQ-017 FIX SHALL negate the quotient when signed and the operand signs differ, and SHALL negate the remainder when signed and the dividend is negative.
REQ-018 FIX SHALL then register o_quotient and o_remainder and enter DONE.
REQ-019 DONE SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-020 Latency SHALL be fixed: if the start cycle is cycle 0, o_done SHALL be high in cycle 34 for every operand value.
REQ-021 Divisor == 0 SHALL give o_quotient=0xFFFFFFFF and o_remainder=dividend, in both signed and unsigned mode, with the same latency.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give o_quotient=0x80000000 and o_remainder=0, with no exception signal.
REQ-023 i_start SHALL be ignored while o_busy=1.
REQ-024 Operand input changes after the accepting edge SHALL have no effect on the current result.
REQ-025 o_quotient and o_remainder SHALL hold their values until the next FIX update.
REQ-026 i_start may be high in the DONE cycle; it is ignored there and accepted the following cycle in IDLE (back-to-back throughput of one result per 35 cycles).

Reset
REQ-027 While i_rst_n=0 the FSM SHALL be IDLE, and o_busy, o_done, o_quotient, o_remainder and all internal registers SHALL be 0, independent of i_clk.
REQ-028 Reset asserted mid-operation SHALL abort the division without producing an o_done pulse.
REQ-029 The first edge after reset release SHALL be able to accept i_start.

Structure
REQ-030 The state enum and the constant DIV_STEPS=32 SHALL live in the shared package with the other ALU definitions.
REQ-031 The trial subtraction SHALL instantiate the existing full_adder_32bit (A + ~B + 1, carry-out = no-borrow); no other sub-module SHALL be used.
REQ-032 Negation SHALL be done as inversion plus one, sharing logic between the operand-magnitude and FIX stages where practical.

Verification
REQ-033 Unsigned 100 / 7 -> o_done in cycle 34, q=14, r=2, o_busy high in cycles 1-34.
REQ-034 Signed 0xFFFFFFF9 (-7) / 2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); unsigned mode with the same operands -> q=0x7FFFFFFC, r=1.
REQ-035 Divide by zero: signed 0xFFFFFFFB / 0 -> q=0xFFFFFFFF, r=0xFFFFFFFB; unsigned 5 / 0 -> q=0xFFFFFFFF, r=5.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, in cycle 34.
REQ-037 Start 20 / 3, then pulse i_start with 9 / 9 in cycle 10 -> the second start is ignored; cycle 34 gives q=6, r=2, and exactly one o_done pulse.
REQ-038 Reset asserted in cycle 12 of a division -> o_busy=0, outputs=0, no o_done; after release, 9 / 9 -> q=1, r=0 after 34 cycles.
